aw_thread_sched: RTL and testbench
==================================

AW_THREAD_SCHED -- requirements
Module: aw_thread_sched

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 64, number of VM threads (power of two, 2..64).
REQ-002 SHALL have parameter PC_W, default 16, bytecode address width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse that begins a VM frame.
REQ-006 SHALL have port frame_done  output  1  one-cycle pulse when every thread has run this frame.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port cpu_start  output  1  one-cycle pulse that launches the CPU core on a thread.
REQ-009 SHALL have port cpu_tid  output  log2(NUM_THREADS)  thread being run; held through RUN.
REQ-010 SHALL have port cpu_pc  output  PC_W  start PC for cpu_tid; held through RUN.
REQ-011 SHALL have port cpu_yield  input  1  pauseThread executed; thread resumes at cpu_yield_pc next frame.
REQ-012 SHALL have port cpu_yield_pc  input  PC_W  resume PC, sampled with cpu_yield.
REQ-013 SHALL have port cpu_kill  input  1  killThread executed; thread becomes inactive.
REQ-014 SHALL have port setvec_valid/setvec_ready  input/output  1  setVec request handshake.
REQ-015 SHALL have port setvec_tid  input  log2(NUM_THREADS)  target thread.
REQ-016 SHALL have port setvec_pc  input  PC_W  requested PC; 0xFFFE = kill request.

Function
REQ-017 SHALL hold per thread cur_pc (0xFFFF = inactive) and req_pc (0xFFFF = no request).
REQ-018 SHALL implement FSM IDLE -> APPLY -> SCAN -> RUN -> SCAN ... -> DONE -> IDLE.
REQ-019 IDLE: frame_start moves to APPLY with index 0; frame_start in any other state SHALL be ignored.
REQ-020 APPLY: one thread per cycle, indices 0..NUM_THREADS-1 (exactly NUM_THREADS cycles); req 0xFFFE sets cur 0xFFFF, req 0xFFFF leaves cur unchanged, any other req copies into cur; req then clears to 0xFFFF.
REQ-021 setvec_ready SHALL be low in APPLY and high in all other states; a transfer (valid&ready) SHALL write req_pc[tid] in that cycle, and a later transfer to the same tid overwrites an earlier one.
REQ-022 SCAN: examines one thread per cycle from index 0 (first entry) or last-run index+1; an active thread moves to RUN; if the index is NUM_THREADS-1 and inactive, moves to DONE.
REQ-023 RUN: cpu_start high in the first RUN cycle only; cpu_tid/cpu_pc stable throughout.
REQ-024 RUN: cpu_yield writes cur_pc[tid]=cpu_yield_pc; cpu_kill writes 0xFFFF; both together: kill wins; either one moves to SCAN at tid+1, or to DONE if tid = NUM_THREADS-1.
REQ-025 cpu_yield/cpu_kill outside RUN SHALL be ignored.
REQ-026 DONE: frame_done high for exactly one cycle, then IDLE.
REQ-027 A setVec accepted during RUN SHALL only take effect at the next frame's APPLY, including for the running thread.

Reset
REQ-028 On reset low: state IDLE; cur_pc[0]=0x0000; all other cur_pc=0xFFFF; all req_pc=0xFFFF.
REQ-029 On reset low: frame_done=0, cpu_start=0, busy=0, cpu_tid=0, cpu_pc=0, setvec_ready=1 on the next edge.
REQ-030 Reset mid-frame SHALL abort the frame without a frame_done pulse.

Configuration
REQ-031 Macro AW_SCHED_SUSPEND_EN defined: adds inputs susp_valid, susp_tid, susp_val, which write a per-thread suspend flag (reset 0); SCAN skips suspended threads; APPLY still updates them.
REQ-032 Macro undefined: no suspend ports or flags; all active threads run.

Structure
REQ-033 Package aw_sched_pkg SHALL hold PC_INACTIVE=0xFFFF, PC_KILL_REQ=0xFFFE, default NUM_THREADS and the FSM state enum.
REQ-034 Sub-module aw_thread_table SHALL hold the cur_pc/req_pc arrays: one write port for cur_pc, one write port for req_pc and one read port.

Verification
REQ-035 Reset, frame_start -> 64 APPLY cycles, then cpu_start with tid 0, pc 0x0000; cpu_yield pc 0x0123 -> frame_done; next frame starts tid 0 at 0x0123.
REQ-036 setvec tid 5 pc 0x0400 during RUN -> no effect this frame; next frame runs tid 0, then tid 5 at 0x0400.
REQ-037 setvec tid 5 pc 0xFFFE -> after next APPLY, tid 5 is skipped; only tid 0 runs.
REQ-038 cpu_yield and cpu_kill together on tid 0 -> tid 0 inactive; next frame has no cpu_start, and frame_done follows 64 APPLY and 64 SCAN cycles.
REQ-039 setvec_valid held high during APPLY -> ready low until SCAN; the request is accepted on the first SCAN cycle.
REQ-040 With AW_SCHED_SUSPEND_EN, suspend tid 0 -> frame runs no thread; unsuspend -> tid 0 resumes at its prior PC.

Source files
------------

// File: rtl/aw_sched_pkg.sv
// Shared constants and FSM state type for the VM thread scheduler.
// PC values are 16-bit sentinels; wider PC_W builds zero-extend them.
package aw_sched_pkg;

  localparam logic [15:0] PC_INACTIVE         = 16'hFFFF;
  localparam logic [15:0] PC_KILL_REQ         = 16'hFFFE;
  localparam int          DEFAULT_NUM_THREADS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SCAN,
    ST_RUN,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/aw_thread_table.sv
// Per-thread PC storage: current PC (inactive sentinel) and pending setVec request.
// One write port per array plus a shared combinational read port.
module aw_thread_table
  import aw_sched_pkg::*;
#(
  parameter  int NUM_THREADS = DEFAULT_NUM_THREADS,
  parameter  int PC_W        = 16,
  localparam int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cur_we,
  input  logic [TID_W-1:0] cur_waddr,
  input  logic [PC_W-1:0]  cur_wdata,
  input  logic             req_we,
  input  logic [TID_W-1:0] req_waddr,
  input  logic [PC_W-1:0]  req_wdata,
  input  logic [TID_W-1:0] rd_addr,
  output logic [PC_W-1:0]  rd_cur,
  output logic [PC_W-1:0]  rd_req
);

  localparam logic [PC_W-1:0] PC_OFF = PC_W'(PC_INACTIVE);

  logic [PC_W-1:0] cur_pc [NUM_THREADS];
  logic [PC_W-1:0] req_pc [NUM_THREADS];

  // NOTE: these arrays are flops, not RAM, because reset must leave thread 0
  // runnable at PC 0 and every other entry inactive; a RAM could not do that.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        cur_pc[i] <= (i == 0) ? '0 : PC_OFF;
        req_pc[i] <= PC_OFF;
      end
    end else begin
      if (cur_we) cur_pc[cur_waddr] <= cur_wdata;
      if (req_we) req_pc[req_waddr] <= req_wdata;
    end
  end

  assign rd_cur = cur_pc[rd_addr];
  assign rd_req = req_pc[rd_addr];

endmodule

// File: rtl/aw_thread_sched.sv
// Frame scheduler: applies pending setVec requests, then launches each active thread once in index order.
// Optional per-thread suspend inputs: define AW_SCHED_SUSPEND_EN.
module aw_thread_sched
  import aw_sched_pkg::*;
#(
  parameter  int NUM_THREADS = DEFAULT_NUM_THREADS,
  parameter  int PC_W        = 16,
  localparam int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             cpu_start,
  output logic [TID_W-1:0] cpu_tid,
  output logic [PC_W-1:0]  cpu_pc,
  input  logic             cpu_yield,
  input  logic [PC_W-1:0]  cpu_yield_pc,
  input  logic             cpu_kill,
`ifdef AW_SCHED_SUSPEND_EN
  input  logic             susp_valid,
  input  logic [TID_W-1:0] susp_tid,
  input  logic             susp_val,
`endif
  input  logic             setvec_valid,
  output logic             setvec_ready,
  input  logic [TID_W-1:0] setvec_tid,
  input  logic [PC_W-1:0]  setvec_pc
);

  localparam logic [PC_W-1:0]  PC_OFF  = PC_W'(PC_INACTIVE);
  localparam logic [PC_W-1:0]  PC_KILL = PC_W'(PC_KILL_REQ);
  localparam logic [TID_W-1:0] LAST    = TID_W'(NUM_THREADS - 1);

  sched_state_t     state, state_next;
  logic [TID_W-1:0] idx, idx_next;
  logic [TID_W-1:0] tid_next;
  logic [PC_W-1:0]  pc_next;
  logic             start_next;
  logic             skip;

  logic             cur_we, req_we;
  logic [TID_W-1:0] cur_waddr, req_waddr;
  logic [PC_W-1:0]  cur_wdata, req_wdata;
  logic [PC_W-1:0]  rd_cur, rd_req;

  aw_thread_table #(
    .NUM_THREADS (NUM_THREADS),
    .PC_W        (PC_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .cur_we    (cur_we),
    .cur_waddr (cur_waddr),
    .cur_wdata (cur_wdata),
    .req_we    (req_we),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rd_addr   (idx),
    .rd_cur    (rd_cur),
    .rd_req    (rd_req)
  );

`ifdef AW_SCHED_SUSPEND_EN
  logic [NUM_THREADS-1:0] susp;

  always_ff @(posedge clk) begin
    if (!reset)          susp           <= '0;
    else if (susp_valid) susp[susp_tid] <= susp_val;
  end

  assign skip = susp[idx];
`else
  assign skip = 1'b0;
`endif

  assign frame_done   = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign setvec_ready = (state != ST_APPLY);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cpu_tid   <= '0;
      cpu_pc    <= '0;
      cpu_start <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      cpu_tid   <= tid_next;
      cpu_pc    <= pc_next;
      cpu_start <= start_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    tid_next   = cpu_tid;
    pc_next    = cpu_pc;
    start_next = 1'b0;
    cur_we     = 1'b0;
    cur_waddr  = idx;
    cur_wdata  = rd_cur;
    req_we     = setvec_valid && setvec_ready;
    req_waddr  = setvec_tid;
    req_wdata  = setvec_pc;

    unique case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_next = ST_APPLY;
          idx_next   = '0;
        end
      end

      ST_APPLY: begin
        // Kill request deactivates, "no request" keeps, anything else is a new PC.
        cur_we = 1'b1;
        if (rd_req == PC_KILL)     cur_wdata = PC_OFF;
        else if (rd_req != PC_OFF) cur_wdata = rd_req;
        req_we    = 1'b1;
        req_waddr = idx;
        req_wdata = PC_OFF;
        if (idx == LAST) begin
          state_next = ST_SCAN;
          idx_next   = '0;
        end else begin
          idx_next = idx + TID_W'(1);
        end
      end

      ST_SCAN: begin
        if (rd_cur != PC_OFF && !skip) begin
          state_next = ST_RUN;
          tid_next   = idx;
          pc_next    = rd_cur;
          start_next = 1'b1;
        end else if (idx == LAST) begin
          state_next = ST_DONE;
        end else begin
          idx_next = idx + TID_W'(1);
        end
      end

      ST_RUN: begin
        if (cpu_yield || cpu_kill) begin
          cur_we    = 1'b1;
          cur_waddr = cpu_tid;
          cur_wdata = cpu_kill ? PC_OFF : cpu_yield_pc;
          if (cpu_tid == LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SCAN;
            idx_next   = cpu_tid + TID_W'(1);
          end
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aw_thread_sched.sv
// Self-checking bench for aw_thread_sched: directed frame table, hand-written corner sequences
// and randomized frames against a frame-level reference model.
module tb_aw_thread_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        cpu_start;
  logic [5:0]  cpu_tid;
  logic [15:0] cpu_pc;
  logic        cpu_yield;
  logic [15:0] cpu_yield_pc;
  logic        cpu_kill;
  logic        setvec_valid;
  logic        setvec_ready;
  logic [5:0]  setvec_tid;
  logic [15:0] setvec_pc;
`ifdef AW_SCHED_SUSPEND_EN
  logic        susp_valid;
  logic [5:0]  susp_tid;
  logic        susp_val;
`endif

  always #5 clk = ~clk;

  aw_thread_sched dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .busy         (busy),
    .cpu_start    (cpu_start),
    .cpu_tid      (cpu_tid),
    .cpu_pc       (cpu_pc),
    .cpu_yield    (cpu_yield),
    .cpu_yield_pc (cpu_yield_pc),
    .cpu_kill     (cpu_kill),
`ifdef AW_SCHED_SUSPEND_EN
    .susp_valid   (susp_valid),
    .susp_tid     (susp_tid),
    .susp_val     (susp_val),
`endif
    .setvec_valid (setvec_valid),
    .setvec_ready (setvec_ready),
    .setvec_tid   (setvec_tid),
    .setvec_pc    (setvec_pc)
  );

  int total = 0;
  int bad   = 0;

  // resp: 0 = yield, 1 = kill, 2 = yield and kill together
  typedef struct {
    logic        sv_en;
    logic [5:0]  sv_tid;
    logic [15:0] sv_pc;
    int          resp;
    logic [15:0] ypc;
    int          n_runs;
    logic [5:0]  t0;
    logic [15:0] p0;
    logic [5:0]  t1;
    logic [15:0] p1;
    int          len;
  } frame_vec_t;

  logic [15:0] m_cur [64];
  logic [15:0] m_req [64];
  logic [5:0]  exp_tid [$];
  logic [15:0] exp_pc  [$];
  logic [5:0]  obs_tid [$];
  logic [15:0] obs_pc  [$];
  int          frame_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_cur[i] = (i == 0) ? 16'h0000 : 16'hFFFF;
      m_req[i] = 16'hFFFF;
    end
  endfunction

  // Frame-level view: settle all pending requests, then the run list is every active thread in order.
  function automatic void model_apply();
    exp_tid.delete();
    exp_pc.delete();
    for (int i = 0; i < 64; i++) begin
      if (m_req[i] == 16'hFFFE)      m_cur[i] = 16'hFFFF;
      else if (m_req[i] != 16'hFFFF) m_cur[i] = m_req[i];
      m_req[i] = 16'hFFFF;
      if (m_cur[i] != 16'hFFFF) begin
        exp_tid.push_back(6'(i));
        exp_pc.push_back(m_cur[i]);
      end
    end
  endfunction

  function automatic logic [15:0] rnd_pc();
    if ($urandom_range(0, 3) == 0) return 16'hFFFE;
    return 16'($urandom_range(0, 16'h7FFF));
  endfunction

  task automatic drive_setvec(input logic [5:0] t, input logic [15:0] p);
    check("setvec_ready_high", setvec_ready, 1'b1);
    setvec_valid = 1'b1;
    setvec_tid   = t;
    setvec_pc    = p;
    m_req[t]     = p;
  endtask

  task automatic run_frame(input bit rnd, input frame_vec_t v);
    int          cyc;
    int          d;
    int          resp;
    logic [15:0] ypc;
    logic [5:0]  t;
    logic [15:0] p;
    obs_tid.delete();
    obs_pc.delete();
    frame_len   = -1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cyc = 0;
    while (cyc < 2000 && !frame_done) begin
      if (cpu_start) begin
        t = cpu_tid;
        p = cpu_pc;
        obs_tid.push_back(t);
        obs_pc.push_back(p);
        if (rnd) begin
          d    = $urandom_range(0, 3);
          resp = $urandom_range(0, 2);
          ypc  = 16'($urandom_range(0, 16'hFFFD));
          if ($urandom_range(0, 1) == 1) drive_setvec(6'($urandom_range(0, 63)), rnd_pc());
        end else begin
          d    = 1;
          resp = v.resp;
          ypc  = v.ypc;
          if (v.sv_en && obs_tid.size() == 1) drive_setvec(v.sv_tid, v.sv_pc);
        end
        for (int k = 0; k < d; k++) begin
          tick();
          cyc++;
          setvec_valid = 1'b0;
          check("cpu_start_one_cycle", cpu_start, 1'b0);
          check("cpu_tid_held", cpu_tid, t);
          check("cpu_pc_held", cpu_pc, p);
        end
        cpu_yield    = (resp != 1);
        cpu_kill     = (resp != 0);
        cpu_yield_pc = ypc;
        tick();
        cyc++;
        setvec_valid = 1'b0;
        cpu_yield    = 1'b0;
        cpu_kill     = 1'b0;
        m_cur[t]     = (resp != 0) ? 16'hFFFF : ypc;
      end else begin
        tick();
        cyc++;
      end
    end
    if (frame_done) frame_len = cyc;
    check("frame_done_seen", frame_done, 1'b1);
    tick();
    check("frame_done_one_cycle", frame_done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  function automatic logic [31:0] obs_t(input int i);
    return (obs_tid.size() > i) ? 32'(obs_tid[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] obs_p(input int i);
    return (obs_pc.size() > i) ? 32'(obs_pc[i]) : 32'hDEAD;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    frame_vec_t vecs [6];
    frame_vec_t v;
    int         low_cnt;
    int         cyc;
    int         starts;
    int         seen;

    reset        = 1'b0;
    frame_start  = 1'b0;
    cpu_yield    = 1'b0;
    cpu_kill     = 1'b0;
    cpu_yield_pc = '0;
    setvec_valid = 1'b0;
    setvec_tid   = '0;
    setvec_pc    = '0;
`ifdef AW_SCHED_SUSPEND_EN
    susp_valid   = 1'b0;
    susp_tid     = '0;
    susp_val     = 1'b0;
`endif
    model_reset();

    // Directed frames, each continuing from the state the previous one left.
    //         sv_en sv_tid sv_pc     resp ypc       n  t0 p0        t1 p1        len
    vecs[0] = '{1'b0, 6'd0, 16'h0000, 0, 16'h0123, 1, 0, 16'h0000, 0, 16'h0000, 130};
    vecs[1] = '{1'b1, 6'd5, 16'h0400, 0, 16'h0123, 1, 0, 16'h0123, 0, 16'h0000, 130};
    vecs[2] = '{1'b0, 6'd0, 16'h0000, 0, 16'h0200, 2, 0, 16'h0123, 5, 16'h0400, 132};
    vecs[3] = '{1'b1, 6'd5, 16'hFFFE, 0, 16'h0300, 2, 0, 16'h0200, 5, 16'h0200, 132};
    vecs[4] = '{1'b0, 6'd0, 16'h0000, 2, 16'h0777, 1, 0, 16'h0300, 0, 16'h0000, 130};
    vecs[5] = '{1'b0, 6'd0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 128};

    tick();
    tick();
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_cpu_start", cpu_start, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_cpu_tid", cpu_tid, 6'd0);
    check("reset_cpu_pc", cpu_pc, 16'h0000);
    check("reset_setvec_ready", setvec_ready, 1'b1);
    reset = 1'b1;
    tick();

    for (int f = 0; f < 6; f++) begin
      run_frame(1'b0, vecs[f]);
      check($sformatf("dir%0d_runs", f), obs_tid.size(), vecs[f].n_runs);
      if (vecs[f].n_runs > 0) begin
        check($sformatf("dir%0d_tid0", f), obs_t(0), vecs[f].t0);
        check($sformatf("dir%0d_pc0", f), obs_p(0), vecs[f].p0);
      end
      if (vecs[f].n_runs > 1) begin
        check($sformatf("dir%0d_tid1", f), obs_t(1), vecs[f].t1);
        check($sformatf("dir%0d_pc1", f), obs_p(1), vecs[f].p1);
      end
      check($sformatf("dir%0d_len", f), frame_len, vecs[f].len);
    end

    // setVec held through APPLY: refused for all 64 cycles, taken on the first SCAN cycle.
    // A stray frame_start in APPLY must not disturb the frame.
    frame_start = 1'b1;
    tick();
    frame_start  = 1'b0;
    check("apply_busy", busy, 1'b1);
    setvec_valid = 1'b1;
    setvec_tid   = 6'd0;
    setvec_pc    = 16'h0010;
    low_cnt      = 0;
    for (int i = 0; i < 64; i++) begin
      if (!setvec_ready) low_cnt++;
      frame_start = (i == 10);
      tick();
    end
    frame_start = 1'b0;
    check("apply_ready_low_cycles", low_cnt, 64);
    check("scan_ready_high", setvec_ready, 1'b1);
    tick();
    setvec_valid = 1'b0;
    cyc    = 65;
    starts = 0;
    while (!frame_done && cyc < 400) begin
      if (cpu_start) starts++;
      tick();
      cyc++;
    end
    check("held_setvec_frame_starts", starts, 0);
    check("held_setvec_frame_len", cyc, 128);
    tick();

    // yield/kill outside RUN must be ignored.
    cpu_yield    = 1'b1;
    cpu_kill     = 1'b1;
    cpu_yield_pc = 16'h0BAD;
    tick();
    tick();
    cpu_yield = 1'b0;
    cpu_kill  = 1'b0;

    v = '{1'b0, 6'd0, 16'h0000, 0, 16'h0123, 1, 0, 16'h0010, 0, 16'h0000, 130};
    run_frame(1'b0, v);
    check("revive_runs", obs_tid.size(), 1);
    check("revive_tid", obs_t(0), 6'd0);
    check("revive_pc", obs_p(0), 16'h0010);
    check("revive_len", frame_len, 130);

    // Reset in the middle of APPLY aborts the frame with no frame_done.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b0;
    tick();
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", setvec_ready, 1'b1);
    check("midreset_cpu_start", cpu_start, 1'b0);
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 200; i++) begin
      if (frame_done || busy) seen++;
      tick();
    end
    check("midreset_no_done", seen, 0);
    model_reset();

    // Randomized frames against the model.
    for (int f = 0; f < 12; f++) begin
      for (int s = 0; s < int'($urandom_range(0, 4)); s++) begin
        drive_setvec(6'($urandom_range(0, 63)), rnd_pc());
        tick();
        setvec_valid = 1'b0;
      end
      model_apply();
      run_frame(1'b1, v);
      check($sformatf("rnd%0d_runs", f), obs_tid.size(), exp_tid.size());
      for (int i = 0; i < exp_tid.size(); i++) begin
        check($sformatf("rnd%0d_tid%0d", f, i), obs_t(i), exp_tid[i]);
        check($sformatf("rnd%0d_pc%0d", f, i), obs_p(i), exp_pc[i]);
      end
    end

`ifdef AW_SCHED_SUSPEND_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    susp_valid = 1'b1;
    susp_tid   = 6'd0;
    susp_val   = 1'b1;
    tick();
    susp_valid = 1'b0;
    v = '{1'b0, 6'd0, 16'h0000, 0, 16'h0042, 0, 0, 16'h0000, 0, 16'h0000, 128};
    run_frame(1'b0, v);
    check("susp_runs", obs_tid.size(), 0);
    check("susp_len", frame_len, 128);
    susp_valid = 1'b1;
    susp_val   = 1'b0;
    tick();
    susp_valid = 1'b0;
    run_frame(1'b0, v);
    check("unsusp_runs", obs_tid.size(), 1);
    check("unsusp_tid", obs_t(0), 6'd0);
    check("unsusp_pc", obs_p(0), 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
